rcd_cfg_access_arbiter: RTL and testbench
=========================================

Name: rcd_cfg_access_arbiter

Overview:
- Shares the RCD configuration register file between two requesters: the I3C slave register port and an internal local requester (training/BIST sequencer).
- The I3C side issues one-cycle read/write strobes. The local side uses a level request held until acknowledged.
- The block serialises accesses onto a single variable-latency register-file handshake.
- Includes round-robin fairness, an ack timeout and sticky error reporting.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 8, register data width.
- TIMEOUT_CYC, 64, maximum BUSY cycles waiting for rf_ack before abort (legal range 2..255).
- ABORT_RDATA, 8'hFF, read data returned on timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i3c_addr  in  ADDR_W  I3C register address, valid with strobe
- i3c_wdata  in  DATA_W  I3C write data, valid with i3c_write
- i3c_write  in  1  one-cycle write strobe
- i3c_read  in  1  one-cycle read strobe
- i3c_rdata  out  DATA_W  read data, valid while i3c_ready is high
- i3c_ready  out  1  one-cycle completion pulse
- loc_req  in  1  local request level, held stable until loc_ack
- loc_we  in  1  local access is a write (1) or read (0)
- loc_addr  in  ADDR_W  local address
- loc_wdata  in  DATA_W  local write data
- loc_rdata  out  DATA_W  read data, valid while loc_ack is high
- loc_ack  out  1  one-cycle completion pulse
- rf_req  out  1  register-file request, held until rf_ack or abort
- rf_we  out  1  register-file write enable
- rf_addr  out  ADDR_W  register-file address
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read data, sampled with rf_ack
- rf_ack  in  1  register-file completion
- busy  out  1  state is not IDLE
- owner  out  1  current/last grant: 0 = I3C, 1 = local
- timeout_err  out  1  sticky: an access was aborted
- i3c_ovf  out  1  sticky: an I3C strobe was dropped
- err_clr  in  1  clears both sticky flags

Behaviour:

Reset: all outputs 0, except owner = 1, so I3C wins the first tie. The I3C pending slot is empty and the state is IDLE. rf_req drops asynchronously if reset is asserted mid-access. An in-flight access is lost, and no ready/ack is generated for it.

I3C capture:
- A strobe sampled at an edge loads a one-deep pending slot holding addr, wdata and we.
- If i3c_write and i3c_read are both high, the access is treated as a write.
- Capture is allowed in any state.
- If the slot is already full, the new strobe is dropped and i3c_ovf is set. The slot contents are unchanged.
- The slot clears on the edge that grants it.

State machine: IDLE, BUSY, RESP.
- IDLE: if any request is pending, grant it and go to BUSY. On the same edge, register rf_req = 1 and rf_we/rf_addr/rf_wdata from the winner, and update owner.
  - Tie: grant the requester not equal to owner (round-robin).
  - A single pending request wins outright.
  - rf_ack seen in IDLE is ignored.
- BUSY: rf_* stay stable, and an 8-bit wait counter increments each cycle.
  - rf_ack is sampled high: capture rf_rdata (0 on writes), drop rf_req, go to RESP.
  - Counter reaches TIMEOUT_CYC-1 without rf_ack: drop rf_req, return ABORT_RDATA (reads) or 0 (writes), set timeout_err, go to RESP.
  - If rf_ack arrives on the same cycle as the timeout, the ack wins and no error is flagged.
- RESP: pulse i3c_ready or loc_ack for exactly one cycle according to owner, with rdata valid. Go to IDLE on the next edge.

Latency:
- I3C strobe at edge E0 → rf_req high after E1 → rf_ack at Ek → ready high during the cycle after Ek.
- Minimum strobe-to-ready is 3 cycles.

Local handshake:
- loc_req must be low at the first edge after loc_ack. The arbiter re-arbitrates only from IDLE, so no duplicate grant occurs.
- Local fields change only while loc_req is low.

Sticky flags:
- err_clr clears timeout_err and i3c_ovf.
- If a set and err_clr occur on the same cycle, the set wins.

rdata outputs hold their last value outside their pulse cycle.

Test Plan:
1. I3C write addr 0x12, data 0xA5; rf_ack 2 cycles after rf_req → rf_we=1, rf_addr=0x12, rf_wdata=0xA5; i3c_ready 1 cycle; no loc_ack.
2. I3C read 0x30 and loc_req read 0x40 at the same edge, out of reset → I3C granted first, then local. Repeat a simultaneous pair → local first (round-robin). rf_rdata 0x11 and 0x22 are returned to the correct ports.
3. Local access in BUSY; I3C strobe 0x05, then a second I3C strobe 0x06 before the grant → 0x05 serviced after local; 0x06 dropped; i3c_ovf=1. err_clr → i3c_ovf=0.
4. rf_ack never asserted, TIMEOUT_CYC=8, I3C read → rf_req drops after 8 BUSY cycles; i3c_ready with rdata 0xFF; timeout_err=1. A subsequent access completes normally.
5. rf_ack on exactly the timeout cycle → rdata = rf_rdata; timeout_err stays 0.
6. rst_n asserted mid-BUSY → rf_req low immediately; no ready/ack; owner=1 after release. New I3C write serviced normally.

Source files
------------

// File: rtl/rcd_cfg_access_arbiter_if.sv
// Bundle of the I3C, local-requester, register-file and status signals of the config arbiter.
// The arbiter uses the master modport; the requesters and register file see the slave modport.
interface rcd_cfg_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] i3c_addr;
    logic [DATA_W-1:0] i3c_wdata;
    logic              i3c_write;
    logic              i3c_read;
    logic [DATA_W-1:0] i3c_rdata;
    logic              i3c_ready;
    logic              loc_req;
    logic              loc_we;
    logic [ADDR_W-1:0] loc_addr;
    logic [DATA_W-1:0] loc_wdata;
    logic [DATA_W-1:0] loc_rdata;
    logic              loc_ack;
    logic              rf_req;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_ack;
    logic              busy;
    logic              owner;
    logic              timeout_err;
    logic              i3c_ovf;
    logic              err_clr;

    modport master (
        input  i3c_addr, i3c_wdata, i3c_write, i3c_read,
        output i3c_rdata, i3c_ready,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output loc_rdata, loc_ack,
        output rf_req, rf_we, rf_addr, rf_wdata,
        input  rf_rdata, rf_ack,
        output busy, owner, timeout_err, i3c_ovf,
        input  err_clr
    );

    modport slave (
        output i3c_addr, i3c_wdata, i3c_write, i3c_read,
        input  i3c_rdata, i3c_ready,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  loc_rdata, loc_ack,
        input  rf_req, rf_we, rf_addr, rf_wdata,
        output rf_rdata, rf_ack,
        input  busy, owner, timeout_err, i3c_ovf,
        output err_clr
    );
endinterface

// File: rtl/rcd_cfg_access_arbiter.sv
// Round-robin arbiter serialising I3C strobes and a local level request onto one register-file handshake.
// Strobe-to-ready is at least 3 cycles; one-deep I3C slot drops overflow strobes, rf wait bounded by TIMEOUT_CYC.
module rcd_cfg_access_arbiter #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 8,
    parameter int                TIMEOUT_CYC = 64,
    parameter logic [DATA_W-1:0] ABORT_RDATA = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    rcd_cfg_access_arbiter_if.master      bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic              slot_vld_q, slot_vld_d;
    logic              slot_we_q, slot_we_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;
    logic              loc_pend_q;
    logic              owner_q, owner_d;
    logic              rf_req_q, rf_req_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] i3c_rdata_q, i3c_rdata_d;
    logic [DATA_W-1:0] loc_rdata_q, loc_rdata_d;
    logic              timeout_err_q, timeout_err_d;
    logic              i3c_ovf_q, i3c_ovf_d;
    logic              grant_loc, grant_i3c, to_set, ovf_set;
    logic [DATA_W-1:0] resp_dat;

    always_comb begin
        state_d      = state_q;
        slot_vld_d   = slot_vld_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        owner_d      = owner_q;
        rf_req_d     = rf_req_q;
        rf_we_d      = rf_we_q;
        rf_addr_d    = rf_addr_q;
        rf_wdata_d   = rf_wdata_q;
        cnt_d        = cnt_q;
        i3c_rdata_d  = i3c_rdata_q;
        loc_rdata_d  = loc_rdata_q;
        grant_loc    = 1'b0;
        grant_i3c    = 1'b0;
        to_set       = 1'b0;
        ovf_set      = 1'b0;
        resp_dat     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (slot_vld_q || loc_pend_q) begin
                    // On a tie the requester that did not hold the last grant wins.
                    grant_loc  = loc_pend_q && (!slot_vld_q || !owner_q);
                    grant_i3c  = !grant_loc;
                    owner_d    = grant_loc;
                    rf_req_d   = 1'b1;
                    rf_we_d    = grant_loc ? bus.loc_we    : slot_we_q;
                    rf_addr_d  = grant_loc ? bus.loc_addr  : slot_addr_q;
                    rf_wdata_d = grant_loc ? bus.loc_wdata : slot_wdata_q;
                    cnt_d      = 8'd0;
                    state_d    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.rf_ack || cnt_q == CNT_LAST) begin
                    rf_req_d = 1'b0;
                    state_d  = ST_RESP;
                    if (bus.rf_ack) begin
                        resp_dat = rf_we_q ? '0 : bus.rf_rdata;
                    end else begin
                        resp_dat = rf_we_q ? '0 : ABORT_RDATA;
                        to_set   = 1'b1;
                    end
                    if (owner_q) loc_rdata_d = resp_dat;
                    else         i3c_rdata_d = resp_dat;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (grant_i3c) slot_vld_d = 1'b0;
        if (bus.i3c_write || bus.i3c_read) begin
            if (slot_vld_q) begin
                ovf_set = 1'b1;
            end else begin
                slot_vld_d   = 1'b1;
                slot_we_d    = bus.i3c_write;
                slot_addr_d  = bus.i3c_addr;
                slot_wdata_d = bus.i3c_wdata;
            end
        end

        timeout_err_d = to_set  | (timeout_err_q & ~bus.err_clr);
        i3c_ovf_d     = ovf_set | (i3c_ovf_q & ~bus.err_clr);
    end

    // loc_req is registered so a strobe and a request arriving on the same edge tie in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_vld_q    <= 1'b0;
            slot_we_q     <= 1'b0;
            slot_addr_q   <= '0;
            slot_wdata_q  <= '0;
            loc_pend_q    <= 1'b0;
            owner_q       <= 1'b1;
            rf_req_q      <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_addr_q     <= '0;
            rf_wdata_q    <= '0;
            cnt_q         <= 8'd0;
            i3c_rdata_q   <= '0;
            loc_rdata_q   <= '0;
            timeout_err_q <= 1'b0;
            i3c_ovf_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_vld_q    <= slot_vld_d;
            slot_we_q     <= slot_we_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            loc_pend_q    <= bus.loc_req;
            owner_q       <= owner_d;
            rf_req_q      <= rf_req_d;
            rf_we_q       <= rf_we_d;
            rf_addr_q     <= rf_addr_d;
            rf_wdata_q    <= rf_wdata_d;
            cnt_q         <= cnt_d;
            i3c_rdata_q   <= i3c_rdata_d;
            loc_rdata_q   <= loc_rdata_d;
            timeout_err_q <= timeout_err_d;
            i3c_ovf_q     <= i3c_ovf_d;
        end
    end

    assign bus.i3c_ready   = (state_q == ST_RESP) && !owner_q;
    assign bus.loc_ack     = (state_q == ST_RESP) &&  owner_q;
    assign bus.i3c_rdata   = i3c_rdata_q;
    assign bus.loc_rdata   = loc_rdata_q;
    assign bus.rf_req      = rf_req_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_addr     = rf_addr_q;
    assign bus.rf_wdata    = rf_wdata_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.owner       = owner_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.i3c_ovf     = i3c_ovf_q;
endmodule

// File: tb/tb_rcd_cfg_access_arbiter.sv
// Directed bench for the config access arbiter: queued rf-side and completion expectations, register-file responder model.
module tb_rcd_cfg_access_arbiter;
    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        int         dly;
    } rf_t;

    typedef struct {
        logic       port;
        logic [7:0] rdata;
    } out_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   last_len = 0;
    rf_t  rf_q[$];
    out_t out_q[$];

    rcd_cfg_access_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rcd_cfg_access_arbiter #(
        .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYC(8), .ABORT_RDATA(8'hFF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rf_t mk_rf(logic we, logic [7:0] addr, logic [7:0] wdata, logic [7:0] rd, int dly);
        rf_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.rd = rd; r.dly = dly;
        return r;
    endfunction

    function automatic out_t mk_out(logic port, logic [7:0] rdata);
        out_t o;
        o.port = port; o.rdata = rdata;
        return o;
    endfunction

    // Register-file model: checks each new request, acks after the queued delay (0 = never).
    initial begin : rf_model
        int  rcnt;
        rf_t cur;
        rcnt = 0;
        cur = mk_rf(1'b0, 8'h00, 8'h00, 8'h00, 1);
        bus.rf_ack = 1'b0;
        bus.rf_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || !bus.rf_req) begin
                if (rst_n && rcnt > 0) last_len = rcnt;
                rcnt = 0;
                bus.rf_ack = 1'b0;
            end else begin
                rcnt++;
                if (rcnt == 1) begin
                    if (rf_q.size() == 0) begin
                        chk("rf_unexpected_req", 32'(rf_q.size()), 32'd1);
                        cur = mk_rf(1'b0, 8'h00, 8'h00, 8'h00, 1);
                    end else begin
                        cur = rf_q.pop_front();
                        chk("rf_we", 32'(bus.rf_we), 32'(cur.we));
                        chk("rf_addr", 32'(bus.rf_addr), 32'(cur.addr));
                        if (cur.we) chk("rf_wdata", 32'(bus.rf_wdata), 32'(cur.wdata));
                    end
                end
                bus.rf_ack = (cur.dly != 0) && (rcnt == cur.dly);
                bus.rf_rdata = cur.rd;
            end
        end
    end

    // Completion monitor: pops the expected completion on every ready/ack pulse.
    initial begin : out_mon
        out_t e;
        forever begin
            @(negedge clk);
            if (bus.i3c_ready || bus.loc_ack) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_completion", 32'(out_q.size()), 32'd1);
                end else begin
                    e = out_q.pop_front();
                    chk("cpl_port", 32'(bus.loc_ack), 32'(e.port));
                    chk("cpl_both", 32'(bus.i3c_ready & bus.loc_ack), 32'd0);
                    chk("cpl_rdata", 32'(e.port ? bus.loc_rdata : bus.i3c_rdata), 32'(e.rdata));
                end
                if (bus.loc_ack) bus.loc_req = 1'b0;
            end
        end
    end

    task automatic strobe(input logic wr, input logic rd, input logic [7:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        bus.i3c_write = wr;
        bus.i3c_read  = rd;
        bus.i3c_addr  = addr;
        bus.i3c_wdata = wdata;
        @(negedge clk);
        bus.i3c_write = 1'b0;
        bus.i3c_read  = 1'b0;
    endtask

    task automatic wait_drain();
        int idle;
        idle = 0;
        for (int i = 0; i < 300 && idle < 4; i++) begin
            @(negedge clk);
            if (rf_q.size() == 0 && out_q.size() == 0 && !bus.busy) idle++;
            else idle = 0;
        end
        chk("drain", 32'(rf_q.size() + out_q.size()), 32'd0);
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.busy) break;
        end
        chk("wait_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        bus.i3c_addr = 8'h00; bus.i3c_wdata = 8'h00; bus.i3c_write = 1'b0; bus.i3c_read = 1'b0;
        bus.loc_req = 1'b0; bus.loc_we = 1'b0; bus.loc_addr = 8'h00; bus.loc_wdata = 8'h00;
        bus.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd1);
        chk("rst_rf_req", 32'(bus.rf_req), 32'd0);
        chk("rst_ready", 32'(bus.i3c_ready | bus.loc_ack), 32'd0);
        chk("rst_flags", 32'({bus.timeout_err, bus.i3c_ovf}), 32'd0);
        chk("rst_rdata", 32'({bus.i3c_rdata, bus.loc_rdata}), 32'd0);
        rst_n = 1'b1;

        // Simultaneous pair out of reset: I3C first, then local.
        rf_q.push_back(mk_rf(1'b0, 8'h30, 8'h00, 8'h11, 2));
        rf_q.push_back(mk_rf(1'b0, 8'h40, 8'h00, 8'h22, 2));
        out_q.push_back(mk_out(1'b0, 8'h11));
        out_q.push_back(mk_out(1'b1, 8'h22));
        @(negedge clk);
        bus.i3c_read = 1'b1; bus.i3c_addr = 8'h30;
        bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h40;
        @(negedge clk);
        bus.i3c_read = 1'b0;
        wait_drain();
        chk("owner_after_pair", 32'(bus.owner), 32'd1);

        // Lone I3C write, ack two cycles after rf_req.
        rf_q.push_back(mk_rf(1'b1, 8'h12, 8'hA5, 8'h5A, 2));
        out_q.push_back(mk_out(1'b0, 8'h00));
        strobe(1'b1, 1'b0, 8'h12, 8'hA5);
        wait_drain();
        chk("ack_len_2", 32'(last_len), 32'd2);
        chk("owner_after_i3c", 32'(bus.owner), 32'd0);

        // Simultaneous pair with owner=I3C: local first.
        rf_q.push_back(mk_rf(1'b0, 8'h41, 8'h00, 8'h22, 1));
        rf_q.push_back(mk_rf(1'b0, 8'h31, 8'h00, 8'h11, 3));
        out_q.push_back(mk_out(1'b1, 8'h22));
        out_q.push_back(mk_out(1'b0, 8'h11));
        @(negedge clk);
        bus.i3c_read = 1'b1; bus.i3c_addr = 8'h31;
        bus.loc_req = 1'b1; bus.loc_we = 1'b0; bus.loc_addr = 8'h41;
        @(negedge clk);
        bus.i3c_read = 1'b0;
        wait_drain();

        // Local write in BUSY, two I3C strobes: second overflows.
        rf_q.push_back(mk_rf(1'b1, 8'h50, 8'h77, 8'h00, 4));
        rf_q.push_back(mk_rf(1'b0, 8'h05, 8'h00, 8'h55, 1));
        out_q.push_back(mk_out(1'b1, 8'h00));
        out_q.push_back(mk_out(1'b0, 8'h55));
        @(negedge clk);
        bus.loc_req = 1'b1; bus.loc_we = 1'b1; bus.loc_addr = 8'h50; bus.loc_wdata = 8'h77;
        wait_busy();
        strobe(1'b0, 1'b1, 8'h05, 8'h00);
        strobe(1'b1, 1'b0, 8'h06, 8'hEE);
        wait_drain();
        chk("ovf_set", 32'(bus.i3c_ovf), 32'd1);
        chk("ovf_no_timeout", 32'(bus.timeout_err), 32'd0);
        pulse_clr();
        chk("ovf_cleared", 32'(bus.i3c_ovf), 32'd0);

        // Read with no ack: abort after 8 BUSY cycles.
        rf_q.push_back(mk_rf(1'b0, 8'h33, 8'h00, 8'h00, 0));
        out_q.push_back(mk_out(1'b0, 8'hFF));
        strobe(1'b0, 1'b1, 8'h33, 8'h00);
        wait_drain();
        chk("timeout_len", 32'(last_len), 32'd8);
        chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);

        // Follow-up access with both strobes high behaves as a write.
        rf_q.push_back(mk_rf(1'b1, 8'h44, 8'h99, 8'hC3, 1));
        out_q.push_back(mk_out(1'b0, 8'h00));
        strobe(1'b1, 1'b1, 8'h44, 8'h99);
        wait_drain();
        chk("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);
        pulse_clr();
        chk("timeout_err_cleared", 32'(bus.timeout_err), 32'd0);

        // Ack on the timeout cycle wins.
        rf_q.push_back(mk_rf(1'b0, 8'h60, 8'h00, 8'h3C, 8));
        out_q.push_back(mk_out(1'b0, 8'h3C));
        strobe(1'b0, 1'b1, 8'h60, 8'h00);
        wait_drain();
        chk("edge_ack_len", 32'(last_len), 32'd8);
        chk("edge_ack_no_err", 32'(bus.timeout_err), 32'd0);

        // Reset mid-BUSY, then a fresh write.
        rf_q.push_back(mk_rf(1'b1, 8'h70, 8'h12, 8'h00, 0));
        strobe(1'b1, 1'b0, 8'h70, 8'h12);
        wait_busy();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_rf_req", 32'(bus.rf_req), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_owner", 32'(bus.owner), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_rf_q", 32'(rf_q.size()), 32'd0);
        rf_q.push_back(mk_rf(1'b1, 8'h71, 8'h34, 8'h00, 1));
        out_q.push_back(mk_out(1'b0, 8'h00));
        strobe(1'b1, 1'b0, 8'h71, 8'h34);
        wait_drain();
        chk("post_rst_owner", 32'(bus.owner), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
